// File: rtl/string01011_hit_counter_if.sv
// Output slot of the string01011 hit counter: a valid/ready handshake that
// carries one completed-window hit count.
//   cnt_data   completed-window hit count, stable while cnt_valid=1
//   cnt_valid  output slot full
//   cnt_ready  consumer accepts; transfer when cnt_valid & cnt_ready
// master = counter side (drives data/valid), slave = consumer side.
interface string01011_hit_counter_if #(
  parameter int CNT_W = 8
) ();
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (output cnt_data, output cnt_valid, input cnt_ready);
  modport slave  (input cnt_data, input cnt_valid, output cnt_ready);
endinterface

// File: rtl/string01011_hit_counter.sv
// Downstream stage of the string01011 Mealy detector. Counts Z hit pulses
// over fixed windows of WINDOW clock cycles, then offers the saturated count
// on a valid/ready output slot. A completed window that finds the slot still
// full (and not draining) is dropped and latches the sticky overrun flag.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   enable   in   1 = count; 0 = abort the partial window and idle
//   Z        in   hit pulse from the detector, sampled only while enable=1
//   cnt      master modport of string01011_hit_counter_if (data/valid/ready)
//   overrun  out  sticky: a completed window was dropped; cleared by reset
module string01011_hit_counter #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             Z,
  string01011_hit_counter_if.master        cnt,
  output logic                             overrun
);

  localparam int               WC_W    = $clog2(WINDOW);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_sum;
  logic             win_end;

  logic [CNT_W-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             slot_free;

  // Saturating add of this cycle's hit. In IDLE acc_q is already 0, so the
  // same sum serves as the cycle-0 value of a fresh window.
  always_comb begin
    acc_sum = acc_q;
    if (Z && (acc_q != CNT_MAX)) begin
      acc_sum = acc_q + CNT_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    acc_d   = acc_q;
    win_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          // This cycle is window cycle 0 and its Z is counted.
          state_d = RUN;
          wc_d    = WC_W'(1);
          acc_d   = acc_sum;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          wc_d    = '0;
          acc_d   = '0;
        end else if (wc_q == WC_LAST) begin
          // Window end: acc_sum is the final count; the next cycle starts a
          // new window without passing through IDLE.
          win_end = 1'b1;
          wc_d    = '0;
          acc_d   = '0;
        end else begin
          wc_d  = wc_q + WC_W'(1);
          acc_d = acc_sum;
        end
      end
      default: begin
        state_d = IDLE;
        wc_d    = '0;
        acc_d   = '0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wc_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      acc_q   <= acc_d;
    end
  end

  // The slot can take a new count if empty, or if it is draining this cycle.
  assign slot_free = !valid_q || cnt.cnt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (win_end) begin
      if (slot_free) begin
        data_q  <= acc_sum;
        valid_q <= 1'b1;
      end else begin
        // Older unread count is kept; the new one is lost.
        overrun_q <= 1'b1;
      end
    end else if (valid_q && cnt.cnt_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign cnt.cnt_data  = data_q;
  assign cnt.cnt_valid = valid_q;
  assign overrun       = overrun_q;

endmodule
